// File: rtl/sram_controller_if.sv
// Cache-side word request interface of the SRAM controller.
// The master holds sram_read/sram_write high until the one-cycle sram_ready pulse.
interface sram_controller_if;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read;
  logic        sram_write;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  // Handshake: a request (read or write high, write wins) is accepted when the
  // controller is idle; address/data are captured at acceptance and later input
  // changes are ignored. sram_ready is high for exactly one cycle on completion;
  // sram_rdata is valid while sram_ready is high and holds the last read value.
  modport master (
    output sram_address, sram_wdata, sram_read, sram_write,
    input  sram_rdata, sram_ready
  );

  modport slave (
    input  sram_address, sram_wdata, sram_read, sram_write,
    output sram_rdata, sram_ready
  );
endinterface

// File: rtl/sram_controller.sv
// 32-bit word to 16-bit asynchronous SRAM bridge: two halfword accesses per word, low half first.
// Optional macro SRAM_LAST_READ_HIT_EN: repeated reads of the last read word complete without SRAM access.
module sram_controller #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [17:0]       SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [16:0] word;
  logic [31:0] wdata;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [16:0] word_next;
  logic        hit;

  // Offset from the SRAM window base, wrapping modulo 2^32, as a word index.
  assign word_next = 17'((bus.sram_address - BASE_ADDR) >> 2);

`ifdef SRAM_LAST_READ_HIT_EN
  logic [29:0] word_full;
  logic [29:0] cur_word;
  logic [29:0] last_word;
  logic        last_valid;

  assign word_full = 30'((bus.sram_address - BASE_ADDR) >> 2);
  assign hit       = last_valid && (last_word == word_full);
`else
  assign hit = 1'b0;
`endif

  assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      word           <= 17'd0;
      wdata          <= 32'd0;
      dq_out         <= 16'd0;
      dq_oe          <= 1'b0;
      bus.sram_rdata <= 32'd0;
      bus.sram_ready <= 1'b0;
      SRAM_ADDR      <= 18'd0;
      SRAM_CE_N      <= 1'b1;
      SRAM_OE_N      <= 1'b1;
      SRAM_WE_N      <= 1'b1;
      SRAM_UB_N      <= 1'b1;
      SRAM_LB_N      <= 1'b1;
`ifdef SRAM_LAST_READ_HIT_EN
      cur_word       <= 30'd0;
      last_word      <= 30'd0;
      last_valid     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.sram_write) begin
            word      <= word_next;
            wdata     <= bus.sram_wdata;
            state     <= WR_LO;
            cnt       <= 4'd0;
            SRAM_ADDR <= {word_next, 1'b0};
            SRAM_CE_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= (LAST == 4'd0);
            dq_oe     <= 1'b1;
            dq_out    <= bus.sram_wdata[15:0];
`ifdef SRAM_LAST_READ_HIT_EN
            last_valid <= 1'b0;
`endif
          end else if (bus.sram_read && hit) begin
            state          <= DONE;
            bus.sram_ready <= 1'b1;
          end else if (bus.sram_read) begin
            word      <= word_next;
            state     <= RD_LO;
            cnt       <= 4'd0;
            SRAM_ADDR <= {word_next, 1'b0};
            SRAM_CE_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            SRAM_OE_N <= 1'b0;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
`ifdef SRAM_LAST_READ_HIT_EN
            cur_word  <= word_full;
`endif
          end
        end

        RD_LO, RD_HI: begin
          if (cnt == LAST) begin
            cnt <= 4'd0;
            if (state == RD_LO) begin
              bus.sram_rdata[15:0] <= SRAM_DQ;
              state                <= RD_HI;
              SRAM_ADDR            <= {word, 1'b1};
            end else begin
              bus.sram_rdata[31:16] <= SRAM_DQ;
              state                 <= DONE;
              bus.sram_ready        <= 1'b1;
              SRAM_CE_N             <= 1'b1;
              SRAM_OE_N             <= 1'b1;
              SRAM_WE_N             <= 1'b1;
              SRAM_UB_N             <= 1'b1;
              SRAM_LB_N             <= 1'b1;
`ifdef SRAM_LAST_READ_HIT_EN
              last_word             <= cur_word;
              last_valid            <= 1'b1;
`endif
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        WR_LO, WR_HI: begin
          if (cnt == LAST) begin
            cnt <= 4'd0;
            if (state == WR_LO) begin
              state     <= WR_HI;
              SRAM_ADDR <= {word, 1'b1};
              SRAM_WE_N <= (LAST == 4'd0);
              dq_out    <= wdata[31:16];
            end else begin
              state          <= DONE;
              bus.sram_ready <= 1'b1;
              dq_oe          <= 1'b0;
              SRAM_CE_N      <= 1'b1;
              SRAM_OE_N      <= 1'b1;
              SRAM_WE_N      <= 1'b1;
              SRAM_UB_N      <= 1'b1;
              SRAM_LB_N      <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
            // WE_N rises for the last cycle so data is held past the write edge.
            if (cnt == LAST - 4'd1) SRAM_WE_N <= 1'b1;
          end
        end

        DONE: begin
          bus.sram_ready <= 1'b0;
          state          <= IDLE;
        end

        default: begin
          state          <= IDLE;
          bus.sram_ready <= 1'b0;
          dq_oe          <= 1'b0;
          SRAM_CE_N      <= 1'b1;
          SRAM_OE_N      <= 1'b1;
          SRAM_WE_N      <= 1'b1;
          SRAM_UB_N      <= 1'b1;
          SRAM_LB_N      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: SRAM device model, per-cycle expected trace, randomized traffic.
`timescale 1ns/1ps
module tb_sram_controller;
  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sram_controller_if bus();
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  logic [2:0]  dbg_state;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_WE_N (we_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .dbg_state (dbg_state)
  );

  // ---------------- SRAM device model ----------------
  logic [15:0] dev_mem [0:262143];
  assign sram_dq = (!ce_n && !oe_n) ? dev_mem[sram_addr] : 16'bz;
  always @(posedge clk)
    if (rst && !ce_n && !we_n && !ub_n && !lb_n) dev_mem[sram_addr] <= sram_dq;

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [int];
  logic [31:0] rd_val = 32'd0;
  logic [29:0] last_word = 30'd0;
  logic        last_valid = 1'b0;

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  typedef struct packed {
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        chk_addr;
    logic [17:0] addr;
    logic        chk_dq;
    logic [15:0] dq;
    logic        ready;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t idle_entry();
    exp_t e;
    e = '0;
    e.ce_n = 1'b1; e.oe_n = 1'b1; e.we_n = 1'b1;
    e.chk_rd = 1'b1; e.rdata = rd_val;
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [17:0] addr_log[$];
  logic [15:0] we_log[$];
  int unsigned ready_log[$];

  always @(negedge clk) begin
    exp_t e;
    if (!ce_n) addr_log.push_back(sram_addr);
    if (!we_n) we_log.push_back(sram_dq);
    if (bus.sram_ready) ready_log.push_back(cyc);
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_entry();
      check("ce_n", 32'(ce_n), 32'(e.ce_n));
      check("ub_n", 32'(ub_n), 32'(e.ce_n));
      check("lb_n", 32'(lb_n), 32'(e.ce_n));
      check("oe_n", 32'(oe_n), 32'(e.oe_n));
      check("we_n", 32'(we_n), 32'(e.we_n));
      check("ready", 32'(bus.sram_ready), 32'(e.ready));
      if (e.chk_addr) check("sram_addr", 32'(sram_addr), 32'(e.addr));
      if (e.chk_dq) check("dq", 32'(sram_dq), 32'(e.dq));
      if (e.chk_rd) check("rdata", bus.sram_rdata, e.rdata);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the DONE cycle.
  task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit scramble);
    logic [31:0] off;
    logic [16:0] wd;
    int          ncyc;
    bit          is_hit;
    exp_t        e;
    off = addr - BASE;
    wd  = off[18:2];
    bus.sram_write   = wr;
    bus.sram_read    = rd;
    bus.sram_address = addr;
    bus.sram_wdata   = wdata;
    exp_q.push_back(idle_entry());
    ncyc = 0;
    if (wr) begin
      for (int ph = 0; ph < 2; ph++)
        for (int i = 0; i < W; i++) begin
          e = '0;
          e.oe_n = 1'b1; e.we_n = (i == W - 1);
          e.chk_addr = 1'b1; e.addr = {wd, ph[0]};
          e.chk_dq = 1'b1; e.dq = ph ? wdata[31:16] : wdata[15:0];
          e.chk_rd = 1'b1; e.rdata = rd_val;
          exp_q.push_back(e);
        end
      ref_mem[int'({wd, 1'b0})] = wdata[15:0];
      ref_mem[int'({wd, 1'b1})] = wdata[31:16];
      last_valid = 1'b0;
      ncyc = 2 * W;
    end else begin
`ifdef SRAM_LAST_READ_HIT_EN
      is_hit = last_valid && (last_word == off[31:2]);
`else
      is_hit = 1'b0;
`endif
      if (!is_hit) begin
        for (int ph = 0; ph < 2; ph++)
          for (int i = 0; i < W; i++) begin
            e = '0;
            e.oe_n = 1'b0; e.we_n = 1'b1;
            e.chk_addr = 1'b1; e.addr = {wd, ph[0]};
            exp_q.push_back(e);
          end
        rd_val = {ref_rd(int'({wd, 1'b1})), ref_rd(int'({wd, 1'b0}))};
        last_word  = off[31:2];
        last_valid = 1'b1;
        ncyc = 2 * W;
      end
    end
    e = idle_entry();
    e.ready = 1'b1;
    exp_q.push_back(e);
    for (int k = 1; k <= ncyc + 1; k++) begin
      @(posedge clk); #1;
      if (scramble && k <= ncyc) begin
        bus.sram_address = $urandom;
        bus.sram_wdata   = $urandom;
        bus.sram_read    = 1'($urandom_range(0, 1));
        bus.sram_write   = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic finish_txn();
    bus.sram_read  = 1'b0;
    bus.sram_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    we_log.delete();
    ready_log.delete();
  endtask

  task automatic check_addrs(input string name, input logic [17:0] exp_a[$]);
    check({name, "_count"}, 32'(addr_log.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < addr_log.size(); i++)
      check(name, 32'(addr_log[i]), 32'(exp_a[i]));
  endtask

  // ---------------- stimulus ----------------
  int unsigned t0;
  int unsigned t1;
  logic [31:0] a;
  int          kind;

  initial begin
    for (int i = 0; i < 262144; i++) dev_mem[i] = 16'h0000;
    bus.sram_address = 32'd0;
    bus.sram_wdata   = 32'd0;
    bus.sram_read    = 1'b0;
    bus.sram_write   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", bus.sram_rdata, 32'd0);
    check("reset_ready", 32'(bus.sram_ready), 32'd0);
    check("reset_addr", 32'(sram_addr), 32'd0);
    check("reset_strobes", {27'd0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1f);
    check("reset_dq_oe", 32'(dut.dq_oe), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Word write: halfword 0 then 1, WE_N low one cycle per phase.
    clear_logs(); t0 = cyc;
    run_txn(1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 1'b0);
    finish_txn();
    check_addrs("wr_addr_seq", '{18'd0, 18'd0, 18'd1, 18'd1});
    check("wr_we_count", 32'(we_log.size()), 32'd2);
    if (we_log.size() == 2) begin
      check("wr_dq_lo", 32'(we_log[0]), 32'h0000_BEEF);
      check("wr_dq_hi", 32'(we_log[1]), 32'h0000_DEAD);
    end
    check("wr_ready_count", 32'(ready_log.size()), 32'd1);
    if (ready_log.size() == 1) check("wr_ready_cycle", ready_log[0], t0 + 5);

    // Read back.
    clear_logs(); t0 = cyc;
    run_txn(1'b0, 1'b1, 32'h0000_0400, 32'd0, 1'b0);
    check("rd_data_pulse", bus.sram_rdata, 32'hDEAD_BEEF);
    finish_txn();
    check("rd_data_hold", bus.sram_rdata, 32'hDEAD_BEEF);
    if (ready_log.size() == 1) check("rd_ready_cycle", ready_log[0], t0 + 5);
    else check("rd_ready_count", 32'(ready_log.size()), 32'd1);

    // Back-to-back reads with the request held through DONE.
    clear_logs(); t0 = cyc;
    run_txn(1'b0, 1'b1, 32'h0000_0404, 32'd0, 1'b0);
    bus.sram_address = 32'h0000_0400;
    @(posedge clk); #1;
    run_txn(1'b0, 1'b1, 32'h0000_0400, 32'd0, 1'b0);
    finish_txn();
    check_addrs("b2b_addr_seq", '{18'd2, 18'd2, 18'd3, 18'd3, 18'd0, 18'd0, 18'd1, 18'd1});
    check("b2b_ready_count", 32'(ready_log.size()), 32'd2);
    if (ready_log.size() == 2) begin
      check("b2b_ready_1", ready_log[0], t0 + 5);
      check("b2b_ready_2", ready_log[1], t0 + 11);
    end

    // Read and write together: write wins.
    clear_logs();
    run_txn(1'b1, 1'b1, 32'h0000_0408, 32'h0BAD_F00D, 1'b0);
    finish_txn();
    check_addrs("both_addr_seq", '{18'd4, 18'd4, 18'd5, 18'd5});
    check("both_rdata", bus.sram_rdata, 32'hDEAD_BEEF);

    // Reset during WR_HI abandons the word after the low half.
    chk_en = 1'b0;
    clear_logs();
    bus.sram_write   = 1'b1;
    bus.sram_address = 32'h0000_0400;
    bus.sram_wdata   = 32'hCAFE_1234;
    repeat (W + 1) @(posedge clk);
    #1;
    check("rst_pre_addr", 32'(sram_addr), 32'd1);
    check("rst_pre_we", 32'(we_n), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("rst_strobes", {27'd0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1f);
    check("rst_dq_oe", 32'(dut.dq_oe), 32'd0);
    check("rst_rdata", bus.sram_rdata, 32'd0);
    bus.sram_write = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_no_ready", 32'(ready_log.size()), 32'd0);
    ref_mem[0] = 16'h1234;
    rd_val     = 32'd0;
    last_valid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk_en = 1'b1;
    run_txn(1'b0, 1'b1, 32'h0000_0400, 32'd0, 1'b0);
    check("rst_readback", bus.sram_rdata, 32'hDEAD_1234);
    finish_txn();

    // Repeated read of the same word, then a write clearing the stored hit.
    clear_logs();
    run_txn(1'b0, 1'b1, 32'h0000_0400, 32'd0, 1'b0);
    finish_txn();
    clear_logs(); t1 = cyc;
    run_txn(1'b0, 1'b1, 32'h0000_0400, 32'd0, 1'b0);
    finish_txn();
`ifdef SRAM_LAST_READ_HIT_EN
    check("hit_no_ce", 32'(addr_log.size()), 32'd0);
    if (ready_log.size() == 1) check("hit_ready_cycle", ready_log[0], t1 + 1);
`else
    check("rep_ce", 32'(addr_log.size()), 32'(4 * W / 2));
    if (ready_log.size() == 1) check("rep_ready_cycle", ready_log[0], t1 + 5);
`endif
    else check("rep_ready_count", 32'(ready_log.size()), 32'd1);
    run_txn(1'b1, 1'b0, 32'h0000_0404, 32'h5555_AAAA, 1'b0);
    finish_txn();
    clear_logs(); t1 = cyc;
    run_txn(1'b0, 1'b1, 32'h0000_0400, 32'd0, 1'b0);
    finish_txn();
    if (ready_log.size() == 1) check("miss_ready_cycle", ready_log[0], t1 + 5);
    else check("miss_ready_count", 32'(ready_log.size()), 32'd1);

    // Randomized traffic over a small address pool plus wrap cases.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = BASE - 32'd4;
        2:       a = BASE + 32'h0007_FFFC;
        default: a = BASE + 4 * $urandom_range(0, 11) + $urandom_range(0, 3);
      endcase
      kind = $urandom_range(0, 9);
      run_txn(kind >= 5 || kind == 0, kind < 5, a, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1)) begin
        finish_txn();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
      end else begin
        @(posedge clk); #1;
      end
    end
    finish_txn();
    repeat (3) @(posedge clk);
    #1;
    check("trace_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits directly downstream of the cache controller and owns the external 16-bit asynchronous SRAM.
- Accepts one 32-bit word read or write at a time on the cache-side sram_* interface.
- Serialises each word into two halfword SRAM accesses (low half first) and signals completion with a one-cycle sram_ready pulse.

Parameters:
- WAIT_CYCLES, 2: clock cycles each halfword access phase lasts; legal range 1..15.
- BASE_ADDR, 1024: byte address that maps to SRAM halfword 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- sram_address  in  32  byte address of the word request from the cache controller.
- sram_wdata  in  32  write data.
- sram_read  in  1  read request, held high until sram_ready.
- sram_write  in  1  write request, held high until sram_ready.
- sram_rdata  out  32  read data; valid while sram_ready=1 and held afterwards.
- sram_ready  out  1  one-cycle completion pulse.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE;
  - sram_rdata=0, sram_ready=0, SRAM_ADDR=0;
  - CE_N=OE_N=WE_N=UB_N=LB_N=1;
  - SRAM_DQ high-Z;
  - wait counter=0.
- Reset mid-transaction abandons the transaction immediately; no ready pulse follows.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE:
  - sram_write=1 goes to WR_LO; else sram_read=1 goes to RD_LO. Write has priority if both are high.
  - On accept, latch word = (sram_address - BASE_ADDR) mod 2^32, then >>2, and latch sram_wdata.
  - Later input changes do not affect the transaction.
- Halfword addresses: low = {word[16:0],1'b0}, high = {word[16:0],1'b1}. Upper word bits are discarded, so addresses wrap modulo 256K halfwords.
- Each phase lasts exactly WAIT_CYCLES cycles. The wait counter clears on phase entry.
- During any phase: CE_N=UB_N=LB_N=0 and SRAM_ADDR is the phase address.
- Read phases:
  - OE_N=0, WE_N=1, DQ high-Z.
  - On the final cycle of the phase, sample SRAM_DQ into sram_rdata[15:0] (RD_LO) or sram_rdata[31:16] (RD_HI).
- Write phases:
  - OE_N=1, WE_N=0.
  - DQ drives wdata[15:0] (WR_LO) or wdata[31:16] (WR_HI).
  - WE_N returns to 1 on the final cycle of each phase; DQ stays driven through that cycle.
- RD_HI and WR_HI go to DONE.
- DONE:
  - sram_ready=1 for one cycle; all strobes inactive.
  - Always returns to IDLE. A request still high in DONE is not re-sampled.
  - A request held or presented in the following IDLE cycle starts a new transaction.
- Latency: request seen in IDLE cycle 0 gives sram_ready in cycle 2*WAIT_CYCLES+1. Back-to-back requests have a period of 2*WAIT_CYCLES+2.
- A request dropped mid-transaction still completes and pulses sram_ready.
- sram_rdata is unchanged by writes and holds the last read value.

Optional Feature:
- Macro SRAM_LAST_READ_HIT_EN.
- Defined:
  - Keep a last-read word address plus a valid flag. The flag is set when a read completes and cleared by reset or by any accepted write.
  - A read in IDLE whose word matches the stored address while valid goes directly to DONE: no SRAM strobes, sram_rdata unchanged, ready in cycle 1.
- Undefined: every read performs both SRAM phases. No extra registers.

Test Plan:
- WAIT_CYCLES=2. Write 0x00000400 with data 0xDEADBEEF:
  - SRAM_ADDR=0 with DQ=0xBEEF, then SRAM_ADDR=1 with DQ=0xDEAD;
  - WE_N low exactly 1 cycle per phase;
  - sram_ready pulses in cycle 5 only.
- Read 0x00000400 after that write, with the SRAM model returning the stored data: sram_rdata=0xDEADBEEF while sram_ready=1 in cycle 5; value holds after the pulse.
- Read 0x00000404 then 0x00000400 with sram_read held high across the first ready (address changed in the DONE cycle): SRAM_ADDR sequence 2,3,0,1; ready pulses in cycles 5 and 11.
- sram_read=1 and sram_write=1 together at 0x00000408: write performed at SRAM_ADDR 4,5; no read phase; sram_rdata unchanged.
- Assert rst=0 during WR_HI: strobes high and DQ high-Z immediately; no ready pulse. After release, a read of 0x00000400 returns the low half written plus the old high half.
- With SRAM_LAST_READ_HIT_EN defined:
  - Two reads of 0x00000400: the second pulses ready in cycle 1 with no CE_N activity.
  - An intervening write to 0x00000404 forces the full 5-cycle read.
